// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports, their response channels and the data-memory RAM bus.
// The arbiter takes the slave side; requesters plus the RAM sit on the master side.
interface data_memory_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_write;
    logic [2:0]  req0_format;
    logic [31:0] req0_address;
    logic [31:0] req0_wdata;
    logic        rsp0_valid;
    logic [31:0] rsp0_rdata;
    logic        rsp0_error;

    logic        req1_valid;
    logic        req1_ready;
    logic        req1_write;
    logic [2:0]  req1_format;
    logic [31:0] req1_address;
    logic [31:0] req1_wdata;
    logic        rsp1_valid;
    logic [31:0] rsp1_rdata;
    logic        rsp1_error;

    logic [14:0] mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    modport slave (
        input  req0_valid, req0_write, req0_format, req0_address, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_error,
        input  req1_valid, req1_write, req1_format, req1_address, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_error,
        output mem_address, mem_byteena, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output req0_valid, req0_write, req0_format, req0_address, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_error,
        output req1_valid, req1_write, req1_format, req1_address, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_error,
        input  mem_address, mem_byteena, mem_data, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the load/store unit (port 0)
// and the debug/DMA loader (port 1); checks requests, lane-shifts stores, aligns/extends loads.
module data_memory_arbiter #(
    parameter logic [31:0] DATA_BEGIN = 32'h0001_0000,
    parameter logic [31:0] DATA_END   = 32'h0001_FFFF
) (
    input  logic                 clock,
    input  logic                 reset,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [14:0] BASE_WORD = DATA_BEGIN[16:2];

    state_t state, state_next;
    logic   last_grant;

    logic        grant_vld_p0;
    logic        grant_port_p0;
    logic        sel_write_p0;
    logic [2:0]  sel_format_p0;
    logic [31:0] sel_address_p0;
    logic [31:0] sel_wdata_p0;
    logic        in_range_p0;
    logic        aligned_p0;
    logic        legal_p0;

    logic        vld_p1;
    logic        rsp_port_p1;
    logic        rsp_load_p1;
    logic        rsp_err_p1;
    logic [1:0]  rsp_offset_p1;
    logic [2:0]  rsp_format_p1;
    logic [31:0] rsp_rdata_p1;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] base;
        case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << offset;
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] q, input logic [1:0] offset,
                                                input logic [2:0] format);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = q >> {offset, 3'b000};
        case (format[1:0])
            2'b00:   result = format[2] ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   result = format[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: result = shifted;
        endcase
        return result;
    endfunction

    // ---- stage p0: grant, request select and checks (combinational) ----
    always_comb begin
        grant_vld_p0  = 1'b0;
        grant_port_p0 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = 1'b0;
            end else if (bus.req1_valid) begin
                grant_vld_p0  = 1'b1;
                grant_port_p0 = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_vld_p0 && !grant_port_p0;
    assign bus.req1_ready = grant_vld_p0 &&  grant_port_p0;

    assign sel_write_p0   = grant_port_p0 ? bus.req1_write   : bus.req0_write;
    assign sel_format_p0  = grant_port_p0 ? bus.req1_format  : bus.req0_format;
    assign sel_address_p0 = grant_port_p0 ? bus.req1_address : bus.req0_address;
    assign sel_wdata_p0   = grant_port_p0 ? bus.req1_wdata   : bus.req0_wdata;

    assign in_range_p0 = (sel_address_p0 >= DATA_BEGIN) && (sel_address_p0 <= DATA_END);

    always_comb begin
        case (sel_format_p0[1:0])
            2'b01:   aligned_p0 = (sel_address_p0[0] == 1'b0);
            2'b10:   aligned_p0 = (sel_address_p0[1:0] == 2'b00);
            default: aligned_p0 = 1'b1;
        endcase
    end

    assign legal_p0 = in_range_p0 && aligned_p0 && (sel_format_p0[1:0] != 2'b11);

    assign bus.mem_address = sel_address_p0[16:2] - BASE_WORD;
    assign bus.mem_data    = sel_wdata_p0 << {sel_address_p0[1:0], 3'b000};
    assign bus.mem_wren    = grant_vld_p0 && legal_p0 && sel_write_p0;
    assign bus.mem_byteena = bus.mem_wren ? lane_mask(sel_format_p0[1:0], sel_address_p0[1:0])
                                          : 4'b0000;

    // ---- stage p0 -> p1: response bookkeeping captured on handshake ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant  <= 1'b1;
            rsp_port_p1 <= 1'b0;
            rsp_load_p1 <= 1'b0;
            rsp_err_p1  <= 1'b0;
        end else if (grant_vld_p0) begin
            last_grant  <= grant_port_p0;
            rsp_port_p1 <= grant_port_p0;
            rsp_load_p1 <= ~sel_write_p0;
            rsp_err_p1  <= ~legal_p0;
        end
    end

    // Lane offset and format are pure datapath; only meaningful while vld_p1 is set.
    always_ff @(posedge clock) begin
        if (grant_vld_p0) begin
            rsp_offset_p1 <= sel_address_p0[1:0];
            rsp_format_p1 <= sel_format_p0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = grant_vld_p0 ? RESP : IDLE;
            RESP:    state_next = grant_vld_p0 ? RESP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---- stage p1: response pulse, RAM data aligned and extended ----
    assign vld_p1 = (state == RESP);

    always_comb begin
        rsp_rdata_p1 = 32'd0;
        if (vld_p1 && rsp_load_p1 && !rsp_err_p1)
            rsp_rdata_p1 = extend_load(bus.mem_q, rsp_offset_p1, rsp_format_p1);
    end

    always_comb begin
        bus.rsp0_valid = 1'b0;
        bus.rsp0_rdata = 32'd0;
        bus.rsp0_error = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp1_rdata = 32'd0;
        bus.rsp1_error = 1'b0;
        if (vld_p1) begin
            if (rsp_port_p1) begin
                bus.rsp1_valid = 1'b1;
                bus.rsp1_rdata = rsp_rdata_p1;
                bus.rsp1_error = rsp_err_p1;
            end else begin
                bus.rsp0_valid = 1'b1;
                bus.rsp0_rdata = rsp_rdata_p1;
                bus.rsp0_error = rsp_err_p1;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: a byte-array reference memory predicts every response, a monitor
// compares the pulses; grants and RAM-side strobes are checked in the request cycle.
`timescale 1ns/1ps
module tb_data_memory_arbiter;
    localparam logic [31:0] DATA_BEGIN = 32'h0001_0000;
    localparam logic [31:0] DATA_END   = 32'h0001_FFFF;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        error;
        int          due;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    rsp_t       exp_q[$];
    logic       model_last = 1'b1;
    logic [7:0] ref_mem [0:65535];
    logic [31:0] ram [0:32767];

    data_memory_arbiter_if bus();

    data_memory_arbiter #(.DATA_BEGIN(DATA_BEGIN), .DATA_END(DATA_END)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural single-port RAM: byte-enabled write, registered read.
    always @(posedge clock) begin
        if (bus.mem_wren)
            for (int b = 0; b < 4; b++)
                if (bus.mem_byteena[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_data[8*b +: 8];
        bus.mem_q <= ram[bus.mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f);
        if (f[1:0] == 2'b00) return 1;
        if (f[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic legal_req(input logic [31:0] a, input logic [2:0] f);
        if (f[1:0] == 2'b11) return 1'b0;
        if (a < DATA_BEGIN || a > DATA_END) return 1'b0;
        return (a % size_bytes(f)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        int n;
        logic [31:0] v;
        logic [15:0] idx;
        n = size_bytes(f);
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            idx = 16'(a - DATA_BEGIN + 32'(i));
            v = v | ({24'd0, ref_mem[idx]} << (8 * i));
        end
        if (!f[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        logic [15:0] idx;
        for (int i = 0; i < size_bytes(f); i++) begin
            idx = 16'(a - DATA_BEGIN + 32'(i));
            ref_mem[idx] = d[8*i +: 8];
        end
    endtask

    // Called just after a rising edge; presents one cycle of requests and checks the grant.
    task automatic step(input logic v0, input logic w0, input logic [2:0] f0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [2:0] f1,
                        input logic [31:0] a1, input logic [31:0] d1);
        logic ga, gp, w, ok;
        logic [2:0] f;
        logic [31:0] a, d;
        logic [3:0] mask;
        rsp_t e;
        bus.req0_valid = v0; bus.req0_write = w0; bus.req0_format = f0;
        bus.req0_address = a0; bus.req0_wdata = d0;
        bus.req1_valid = v1; bus.req1_write = w1; bus.req1_format = f1;
        bus.req1_address = a1; bus.req1_wdata = d1;
        @(negedge clock);
        ga = v0 | v1;
        gp = (v0 && v1) ? ~model_last : v1;
        check("req0_ready", 32'(bus.req0_ready), 32'(ga && !gp));
        check("req1_ready", 32'(bus.req1_ready), 32'(ga && gp));
        if (ga) begin
            w = gp ? w1 : w0;
            f = gp ? f1 : f0;
            a = gp ? a1 : a0;
            d = gp ? d1 : d0;
            ok = legal_req(a, f);
            mask = 4'b0000;
            if (ok && w)
                for (int i = 0; i < size_bytes(f); i++) mask[a[1:0] + i] = 1'b1;
            check("mem_wren", 32'(bus.mem_wren), 32'(ok && w));
            check("mem_byteena", 32'(bus.mem_byteena), 32'(mask));
            if (ok) check("mem_address", 32'(bus.mem_address), (a - DATA_BEGIN) >> 2);
            if (ok && w) check("mem_data", bus.mem_data, d << (8 * a[1:0]));
            e.port  = gp;
            e.error = ~ok;
            e.rdata = (ok && !w) ? model_load(a, f) : 32'd0;
            e.due   = cyc + 1;
            exp_q.push_back(e);
            if (ok && w) model_store(a, f, d);
            model_last = gp;
        end else begin
            check("idle_wren", 32'(bus.mem_wren), 32'd0);
            check("idle_byteena", 32'(bus.mem_byteena), 32'd0);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic req0(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        step(1'b1, w, f, a, d, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    task automatic req1(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, w, f, a, d);
    endtask

    task automatic reset_outputs(input string tag);
        check({tag, "_rsp0_valid"}, 32'(bus.rsp0_valid), 32'd0);
        check({tag, "_rsp1_valid"}, 32'(bus.rsp1_valid), 32'd0);
        check({tag, "_rsp0_rdata"}, bus.rsp0_rdata, 32'd0);
        check({tag, "_rsp1_rdata"}, bus.rsp1_rdata, 32'd0);
        check({tag, "_rsp0_error"}, 32'(bus.rsp0_error), 32'd0);
        check({tag, "_rsp1_error"}, 32'(bus.rsp1_error), 32'd0);
        check({tag, "_mem_wren"}, 32'(bus.mem_wren), 32'd0);
        check({tag, "_mem_byteena"}, 32'(bus.mem_byteena), 32'd0);
    endtask

    // Response monitor: pops the scoreboard whenever a pulse appears, flags missing ones.
    always @(negedge clock) begin
        rsp_t e;
        if (bus.rsp0_valid && bus.rsp1_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_both: got two valid pulses expected one (cycle %0d)", cyc);
        end else if (bus.rsp0_valid || bus.rsp1_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got a pulse on port %0d expected none (cycle %0d)",
                         bus.rsp1_valid, cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_port", 32'(bus.rsp1_valid), 32'(e.port));
                check("rsp_latency", 32'(cyc), 32'(e.due));
                check("rsp_rdata", e.port ? bus.rsp1_rdata : bus.rsp0_rdata, e.rdata);
                check("rsp_error", 32'(e.port ? bus.rsp1_error : bus.rsp0_error), 32'(e.error));
            end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL rsp_missing: got no pulse expected one on port %0d (cycle %0d)",
                     exp_q[0].port, cyc);
            void'(exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected end of run (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v0, v1, w0, w1;
        logic [2:0] f0, f1;
        logic [31:0] a0, a1, d0, d1;
        for (int i = 0; i < 32768; i++) ram[i] = 32'd0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'd0;
        bus.req0_valid = 1'b0; bus.req0_write = 1'b0; bus.req0_format = 3'd0;
        bus.req0_address = 32'd0; bus.req0_wdata = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_write = 1'b0; bus.req1_format = 3'd0;
        bus.req1_address = 32'd0; bus.req1_wdata = 32'd0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Conflict from reset: grants 0,1,0,1 with port 1 reading port 0's word.
        repeat (4) step(1'b1, 1'b1, 3'b010, 32'h0001_0020, 32'h1111_1111,
                        1'b1, 1'b0, 3'b010, 32'h0001_0020, 32'd0);
        idle();

        req0(1'b1, 3'b000, 32'h0001_0003, 32'h0000_00A5);
        req0(1'b0, 3'b000, 32'h0001_0003, 32'd0);
        req0(1'b0, 3'b100, 32'h0001_0003, 32'd0);

        req0(1'b0, 3'b001, 32'h0001_0001, 32'd0);
        req1(1'b1, 3'b010, 32'h0002_0000, 32'hDEAD_BEEF);
        req0(1'b1, 3'b011, 32'h0001_0000, 32'hDEAD_BEEF);
        req1(1'b0, 3'b010, DATA_END + 32'd1, 32'd0);
        req0(1'b0, 3'b000, DATA_BEGIN - 32'd1, 32'd0);
        req1(1'b1, 3'b010, DATA_END - 32'd3, 32'h8765_4321);
        req0(1'b0, 3'b101, DATA_END - 32'd1, 32'd0);

        req0(1'b1, 3'b010, 32'h0001_0010, 32'h1234_5678);
        req0(1'b0, 3'b001, 32'h0001_0012, 32'd0);
        idle();

        // Reset while a response is pending: no pulse, arbitration restarts at port 0.
        req1(1'b0, 3'b010, 32'h0001_0010, 32'd0);
        reset = 1'b1;
        exp_q.delete();
        model_last = 1'b1;
        @(negedge clock);
        reset_outputs("midreset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) step(1'b1, 1'b0, 3'b010, 32'h0001_0010, 32'd0,
                        1'b1, 1'b0, 3'b110, 32'h0001_0020, 32'd0);

        for (int n = 0; n < 400; n++) begin
            v0 = ($urandom_range(0, 9) < 7);
            v1 = ($urandom_range(0, 9) < 6);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            f0 = 3'($urandom_range(0, 7));
            f1 = 3'($urandom_range(0, 7));
            d0 = $urandom;
            d1 = $urandom;
            case ($urandom_range(0, 9))
                0:       a0 = DATA_BEGIN - 32'd1 - 32'($urandom_range(0, 7));
                1:       a0 = DATA_END + 32'd1 + 32'($urandom_range(0, 7));
                2, 3, 4: a0 = DATA_END - 32'($urandom_range(0, 63));
                default: a0 = DATA_BEGIN + 32'($urandom_range(0, 63));
            endcase
            a1 = ($urandom_range(0, 1) == 1) ? DATA_BEGIN + 32'($urandom_range(0, 63))
                                             : DATA_END - 32'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) a1 = $urandom;
            step(v0, w0, f0, a0, d0, v1, w1, f1, a1, d1);
        end

        repeat (3) idle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Shares the single-port synchronous data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA loader). It arbitrates round-robin, generates byte enables and lane-shifted write data, and captures, lane-aligns and sign/zero-extends read data. It range- and alignment-checks every request. It sits between the requesters and the `data_memory` RAM, which has a 15-bit word address, `byteena`, `wren` and a registered `q`.

## Interface
- `DATA_BEGIN`, default 32'h0001_0000: first byte address mapped to data memory.
- `DATA_END`, default 32'h0001_FFFF: last byte address mapped to data memory; inclusive.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `reqN_valid`  in  1  request present on port N (N = 0, 1).
- `reqN_ready`  out  1  request on port N accepted this cycle.
- `reqN_write`  in  1  1 = store, 0 = load.
- `reqN_format`  in  3  [1:0] size: 00 = byte, 01 = half, 10 = word, 11 = illegal; [2] = 1 zero-extend, 0 sign-extend.
- `reqN_address`  in  32  byte address.
- `reqN_wdata`  in  32  store data, right-aligned.
- `rspN_valid`  out  1  one-cycle response pulse.
- `rspN_rdata`  out  32  extended load data; 0 for stores and errors.
- `rspN_error`  out  1  request was out of range, misaligned or illegal format.
- `mem_address`  out  15  word address to RAM: `address[16:2]` minus the base.
- `mem_byteena`  out  4  byte enables.
- `mem_data`  out  32  lane-shifted write data.
- `mem_wren`  out  1  RAM write strobe.
- `mem_q`  in  32  RAM read data, valid the cycle after the address is presented.

## Operation
- **Arbitration register `last_grant`:**
  - Reset value 1, so port 0 wins the first conflict.
  - When both ports are valid, grant the port not equal to `last_grant`.
  - When one port is valid, grant it.
  - On every grant, `last_grant` := granted port.
- **Grant is combinational:** `reqN_ready` = 1 for exactly the granted port; the handshake completes on `valid && ready`. At most one ready per cycle.
- **Checks on the granted request:**
  - in range = `DATA_BEGIN <= address <= DATA_END`;
  - aligned = byte always; half needs `address[0]==0`; word needs `address[1:0]==0`;
  - `format[1:0]==11` is illegal.
  - Any failure: `mem_wren`=0 and `mem_byteena`=0; the response carries `error`=1 and `rdata`=0.
- **Legal store:**
  - `mem_wren`=1;
  - `mem_byteena` = {0001, 0011, 1111}[size] << `address[1:0]`;
  - `mem_data` = `wdata` << 8·`address[1:0]`.
- **Legal load:** `mem_wren`=0, `mem_byteena`=0, address driven.
- **No grant:** `mem_wren`=0, `mem_byteena`=0; `mem_address`/`mem_data` don't-care.
- **FSM, states IDLE and RESP:**
  - IDLE → RESP on any handshake.
  - RESP → RESP on a new handshake in the same cycle (back-to-back).
  - RESP → IDLE otherwise.
- **Registered on handshake:** `rsp_port`, `rsp_load`, `rsp_err`, `rsp_offset`=`address[1:0]`, `rsp_format`.
- **Response (state RESP):**
  - `rspP_valid`=1 for P = `rsp_port`; the other port's valid = 0.
  - Load `rdata` = (`mem_q` >> 8·`rsp_offset`), truncated to size, sign- or zero-extended per `format[2]`; word passes through.
  - Stores return `rdata`=0, `error`=0.
- Responses cannot be back-pressured; requesters must accept the pulse.

## Timing
- **Reset values:** state IDLE, `last_grant`=1, all `rsp*_valid`=0, `rsp*_rdata`=0, `rsp*_error`=0, `mem_wren`=0, `mem_byteena`=0.
- **Reset mid-operation:** a pending response is discarded with no pulse. A store whose handshake cycle completed before reset has already written.
- **Latency:** response exactly 1 cycle after the handshake cycle.
- **Throughput:** one request per cycle; a request accepted in cycle t responds in t+1 while a new one is accepted in t+1.
- **Store then load to the same word in consecutive cycles:** the load returns the new data, because the RAM write occurs at the edge ending cycle t and the read at the edge ending t+1.
- **Timing path:** `reqN_ready` and the `mem_*` outputs are combinational from `reqN_*` and `last_grant`; `rsp*` are a combinational function of registered state and `mem_q`.
- **Out of range:** `address = DATA_END+1`, or `address < DATA_BEGIN`, gives an error. `DATA_END-3` with word size is legal.

## Test plan
1. **Single store:** port 0 stores byte 0xA5 at 0x0001_0003 → same cycle `mem_byteena`=1000, `mem_data`=0xA500_0000, `mem_wren`=1; next cycle `rsp0_valid`=1, `error`=0.
2. **Signed vs. unsigned load:** port 0 loads signed byte at 0x0001_0003, then unsigned byte at the same address → `rdata` 0xFFFF_FFA5, then 0x0000_00A5, on consecutive cycles.
3. **Conflict:** both ports valid for 4 cycles from reset → grants 0, 1, 0, 1; the responses follow, each one cycle later on the matching port.
4. **Error cases:**
   - half load at 0x0001_0001 → `rsp_error`=1, `rdata`=0, `mem_byteena`=0;
   - word store at 0x0002_0000 → error, no write;
   - `format` 011 → error, no write.
5. **Back-to-back RAW:** word store 0x1234_5678 at 0x0001_0010, next cycle signed half load at 0x0001_0012 → `rdata` 0x0000_1234.
6. **Reset during RESP:** assert `reset` after a load handshake → no `rsp_valid` pulse. After deassert, a conflict grants port 0 first.
